// File: rtl/lfsr_seeded.sv
// Seedable Fibonacci LFSR with load/run/hold control, zero-seed substitution,
// a step counter and detection of the sequence returning to the loaded seed.
module lfsr_seeded #(
  parameter int unsigned      WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS       = 4'b1100,
  parameter logic [WIDTH-1:0] RESET_SEED = 4'b1111,
  parameter int unsigned      CW         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  output logic             seed_err,
  output logic [CW-1:0]    step_cnt,
  output logic             period_done,
  output logic [CW-1:0]    period_len
);

  localparam logic [WIDTH-1:0] ZERO_SUB = WIDTH'(1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] seed_reg_q, seed_reg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    len_q, len_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             fb;
  logic [WIDTH-1:0] shifted;

  assign fb      = ^(lfsr_q & TAPS);
  assign shifted = {lfsr_q[WIDTH-2:0], fb};

  always_comb begin
    // NOTE: every next-state signal gets its default first, so no path can infer a latch.
    lfsr_d     = lfsr_q;
    seed_reg_d = seed_reg_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    err_d      = 1'b0;
    done_d     = 1'b0;

    if (load) begin
      if (seed != '0) begin
        lfsr_d     = seed;
        seed_reg_d = seed;
      end else begin
        // An all-zero seed would lock the register up; substitute 1 and flag it.
        lfsr_d     = ZERO_SUB;
        seed_reg_d = ZERO_SUB;
        err_d      = 1'b1;
      end
      cnt_d = '0;
    end else if (enable) begin
      lfsr_d = shifted;
      if (shifted == seed_reg_q) begin
        done_d = 1'b1;
        len_d  = cnt_q + CNT_ONE;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only; every register here is reset.
    if (!rst_n) begin
      lfsr_q     <= RESET_SEED;
      seed_reg_q <= RESET_SEED;
      cnt_q      <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      seed_reg_q <= seed_reg_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign q           = lfsr_q;
  assign seed_err    = err_q;
  assign step_cnt    = cnt_q;
  assign period_done = done_q;
  assign period_len  = len_q;

endmodule
